// File: rtl/wb_load_if.sv
// wb_load_if: execute-side, data-memory and register-file write-port signals of the write-back stage.
interface wb_load_if;
  logic        ex_valid;
  logic        ex_ready;
  logic        ex_is_load;
  logic [4:0]  ex_rd;
  logic [31:0] ex_result;
  logic [2:0]  ex_funct3;
  logic [1:0]  ex_addr_lo;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        rf_we;
  logic [4:0]  rf_wraddr;
  logic [31:0] rf_wrdata;
  logic        err_timeout;
  modport slave (
    input  ex_valid, ex_is_load, ex_rd, ex_result, ex_funct3, ex_addr_lo, mem_rvalid, mem_rdata,
    output ex_ready, rf_we, rf_wraddr, rf_wrdata, err_timeout
  );
  modport master (
    output ex_valid, ex_is_load, ex_rd, ex_result, ex_funct3, ex_addr_lo, mem_rvalid, mem_rdata,
    input  ex_ready, rf_we, rf_wraddr, rf_wrdata, err_timeout
  );
endinterface

// File: rtl/wb_load_unit.sv
// wb_load_unit: write-back stage; writes ALU results, waits for and formats load data.
// Optional WB_TIMEOUT_EN abandons a load after TIMEOUT_CYCLES wait cycles without a response.
module wb_load_unit #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic rst,
  wb_load_if.slave bus_io
);
  typedef enum logic {IDLE, WAIT_LOAD} state_t;
  state_t      state_q;
  logic [4:0]  rd_q;
  logic [2:0]  funct3_q;
  logic [1:0]  addr_lo_q;
  logic        we_q;
  logic [4:0]  wraddr_q;
  logic [31:0] wrdata_q;
  logic [7:0]  bsel;
  logic [15:0] hsel;
  logic [31:0] load_data;
  logic        accept;
  assign accept = bus_io.ex_valid && (state_q == IDLE);
  assign bus_io.ex_ready = (state_q == IDLE);
  assign bus_io.rf_we = we_q;
  assign bus_io.rf_wraddr = wraddr_q;
  assign bus_io.rf_wrdata = wrdata_q;
  always_comb begin
    bsel = bus_io.mem_rdata[{addr_lo_q, 3'b000} +: 8];
    hsel = addr_lo_q[1] ? bus_io.mem_rdata[31:16] : bus_io.mem_rdata[15:0];
    load_data = funct3_q == 3'b000 ? {{24{bsel[7]}}, bsel} :
                funct3_q == 3'b001 ? {{16{hsel[15]}}, hsel} :
                funct3_q == 3'b100 ? {24'b0, bsel} :
                funct3_q == 3'b101 ? {16'b0, hsel} : bus_io.mem_rdata;
  end
`ifdef WB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;
  assign bus_io.err_timeout = err_q;
`else
  localparam int unused_timeout = TIMEOUT_CYCLES + CNT_W;
  assign bus_io.err_timeout = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rd_q <= '0;
      funct3_q <= '0;
      addr_lo_q <= '0;
      we_q <= 1'b0;
      wraddr_q <= '0;
      wrdata_q <= '0;
`ifdef WB_TIMEOUT_EN
      cnt_q <= '0;
      err_q <= 1'b0;
`endif
    end else begin
      we_q <= 1'b0;
`ifdef WB_TIMEOUT_EN
      err_q <= 1'b0;
`endif
      // x0 writes are suppressed entirely so address/data keep the last real write
      if (state_q == IDLE) begin
        if (accept && bus_io.ex_is_load) begin
          rd_q <= bus_io.ex_rd;
          funct3_q <= bus_io.ex_funct3;
          addr_lo_q <= bus_io.ex_addr_lo;
          state_q <= WAIT_LOAD;
`ifdef WB_TIMEOUT_EN
          cnt_q <= '0;
`endif
        end else if (accept && bus_io.ex_rd != 5'd0) begin
          we_q <= 1'b1;
          wraddr_q <= bus_io.ex_rd;
          wrdata_q <= bus_io.ex_result;
        end
      end else if (bus_io.mem_rvalid) begin
        state_q <= IDLE;
        if (rd_q != 5'd0) begin
          we_q <= 1'b1;
          wraddr_q <= rd_q;
          wrdata_q <= load_data;
        end
`ifdef WB_TIMEOUT_EN
      end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
        state_q <= IDLE;
        err_q <= 1'b1;
      end else begin
        cnt_q <= cnt_q + 1'b1;
`endif
      end
    end
  end
endmodule

// File: tb/tb_wb_load_unit.sv
// tb_wb_load_unit: directed and randomized checks of wb_load_unit against a spec-level model.
module tb_wb_load_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int vectors = 0;
  int miscompares = 0;
  logic [4:0]  last_addr = '0;
  logic [31:0] last_data = '0;
  wb_load_if bus();
  wb_load_unit #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (.clk(clk), .rst(rst), .bus_io(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_port(input string tag, input logic we, input logic ready, input logic err);
    chk({tag, ".we"}, {31'b0, bus.rf_we}, {31'b0, we});
    chk({tag, ".ready"}, {31'b0, bus.ex_ready}, {31'b0, ready});
    chk({tag, ".err"}, {31'b0, bus.err_timeout}, {31'b0, err});
    chk({tag, ".addr"}, {27'b0, bus.rf_wraddr}, {27'b0, last_addr});
    chk({tag, ".data"}, bus.rf_wrdata, last_data);
  endtask

  function automatic logic [31:0] fmt(input logic [2:0] f, input logic [1:0] a, input logic [31:0] w);
    int unsigned b, h;
    b = (w >> (8 * a)) & 32'hFF;
    h = (w >> (a[1] ? 16 : 0)) & 32'hFFFF;
    case (f)
      3'd0: return b + (b >= 128 ? 32'hFFFF_FF00 : 32'h0);
      3'd1: return h + (h >= 32768 ? 32'hFFFF_0000 : 32'h0);
      3'd4: return b;
      3'd5: return h;
      default: return w;
    endcase
  endfunction

  task automatic alu(input logic [4:0] rd, input logic [31:0] res);
    bus.ex_valid = 1'b1; bus.ex_is_load = 1'b0; bus.ex_rd = rd; bus.ex_result = res;
    tick();
    bus.ex_valid = 1'b0;
    if (rd != 0) begin last_addr = rd; last_data = res; end
    chk_port("alu", rd != 0, 1'b1, 1'b0);
  endtask

  task automatic load(input logic [2:0] f, input logic [1:0] a, input logic [4:0] rd,
                      input logic [31:0] w, input int delay, input logic early);
    bus.ex_valid = 1'b1; bus.ex_is_load = 1'b1; bus.ex_rd = rd; bus.ex_funct3 = f;
    bus.ex_addr_lo = a; bus.mem_rvalid = early; bus.mem_rdata = ~w;
    tick();
    bus.ex_valid = 1'b0; bus.mem_rvalid = 1'b0;
    chk_port("ld_acc", 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < delay; i++) begin
      tick();
      chk_port("ld_wait", 1'b0, 1'b0, 1'b0);
    end
    bus.mem_rvalid = 1'b1; bus.mem_rdata = w;
    tick();
    bus.mem_rvalid = 1'b0;
    if (rd != 0) begin last_addr = rd; last_data = fmt(f, a, w); end
    chk_port("ld_resp", rd != 0, 1'b1, 1'b0);
  endtask

  initial begin
    bus.ex_valid = 1'b0; bus.ex_is_load = 1'b0; bus.ex_rd = '0; bus.ex_result = '0;
    bus.ex_funct3 = '0; bus.ex_addr_lo = '0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    #12;
    chk_port("reset", 1'b0, 1'b1, 1'b0);
    rst = 1'b0;
    tick();
    alu(5'd5, 32'h1234_5678);
    alu(5'd6, 32'hCAFE_BABE);
    alu(5'd0, 32'hFFFF_FFFF);
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h1111_1111;
    tick();
    bus.mem_rvalid = 1'b0;
    chk_port("idle_rvalid", 1'b0, 1'b1, 1'b0);
    load(3'b000, 2'd3, 5'd1, 32'h80FF_7F01, 3, 1'b0);
    chk("lb", bus.rf_wrdata, 32'hFFFF_FF80);
    load(3'b100, 2'd1, 5'd2, 32'h80FF_7F01, 3, 1'b0);
    chk("lbu", bus.rf_wrdata, 32'h0000_007F);
    load(3'b001, 2'd2, 5'd3, 32'h80FF_7F01, 3, 1'b0);
    chk("lh", bus.rf_wrdata, 32'hFFFF_80FF);
    load(3'b101, 2'd0, 5'd4, 32'h80FF_7F01, 3, 1'b0);
    chk("lhu", bus.rf_wrdata, 32'h0000_7F01);
    load(3'b010, 2'd0, 5'd7, 32'h80FF_7F01, 3, 1'b0);
    chk("lw", bus.rf_wrdata, 32'h80FF_7F01);
    load(3'b010, 2'd0, 5'd8, 32'h0BAD_F00D, 0, 1'b1);
    alu(5'd9, 32'h0000_0042);
    load(3'b010, 2'd0, 5'd0, 32'hDEAD_BEEF, 2, 1'b0);
    alu(5'd10, 32'h0000_00AA);
    // asynchronous reset in the middle of a load wait
    bus.ex_valid = 1'b1; bus.ex_is_load = 1'b1; bus.ex_rd = 5'd11; bus.ex_funct3 = 3'b010;
    tick();
    bus.ex_valid = 1'b0;
    tick();
    #2 rst = 1'b1;
    #1;
    last_addr = '0; last_data = '0;
    chk_port("async_rst", 1'b0, 1'b1, 1'b0);
    tick();
    rst = 1'b0;
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h5555_AAAA;
    tick();
    bus.mem_rvalid = 1'b0;
    chk_port("post_rst", 1'b0, 1'b1, 1'b0);
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(1, 0) == 1)
        alu(5'($urandom_range(31, 0)), $urandom);
      else
        load(3'($urandom_range(7, 0)), 2'($urandom_range(3, 0)), 5'($urandom_range(31, 0)),
             $urandom, $urandom_range(4, 0), 1'($urandom_range(1, 0)));
    end
`ifdef WB_TIMEOUT_EN
    bus.ex_valid = 1'b1; bus.ex_is_load = 1'b1; bus.ex_rd = 5'd12; bus.ex_funct3 = 3'b010;
    tick();
    bus.ex_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_port("to_wait", 1'b0, 1'b0, 1'b0);
    end
    tick();
    chk_port("to_fire", 1'b0, 1'b1, 1'b1);
    tick();
    chk_port("to_after", 1'b0, 1'b1, 1'b0);
    load(3'b010, 2'd0, 5'd13, 32'h1357_9BDF, 3, 1'b0);
    chk("to_race", bus.rf_wrdata, 32'h1357_9BDF);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
